// File: rtl/bank_eraser.sv
// bank_eraser: AXI4 write master that fills one RAM bank with a fixed pattern.
// Full-length INCR bursts are issued with a bounded number awaiting their write response.
module bank_eraser #(
    parameter int          DW              = 512,
    parameter logic [63:0] BASE_ADDR       = 64'h0,
    parameter logic [63:0] BANK_SIZE       = 64'h1_0000_0000,
    parameter int          BURST_BEATS     = 64,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [31:0] FILL_PATTERN    = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            erase_ram,
    output logic            erase_idle,
    output logic [15:0]     error_count,
    output logic [63:0]     M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);
    // state | meaning
    // IDLE  | no erase in progress, waiting for erase_ram
    // RUN   | issuing bursts and collecting write responses
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [63:0] BURST_BYTES = 64'(BURST_BEATS) * 64'(DW / 8);
    localparam logic [63:0] TOTAL       = BANK_SIZE / BURST_BYTES;
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_BEATS - 1);
    localparam logic [7:0]  MAX_OUT     = 8'(MAX_OUTSTANDING);

    logic [0:0]  state;
    logic [63:0] aw_sent;
    logic [63:0] w_bursts_done;
    logic [63:0] b_rcvd;
    logic [63:0] aw_addr;
    logic [7:0]  outstanding;
    logic [7:0]  beat;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;

    // AWVALID can only stay asserted while waiting: outstanding never grows without a handshake
    assign M_AXI_AWVALID = (state == RUN) && (aw_sent < TOTAL) && (outstanding < MAX_OUT);
    assign M_AXI_WVALID  = (state == RUN) && (w_bursts_done < aw_sent);
    assign M_AXI_BREADY  = (state == RUN);
    assign M_AXI_WLAST   = (beat == LAST_BEAT);
    assign erase_idle    = (state == IDLE);

    assign M_AXI_AWADDR  = aw_addr;
    assign M_AXI_AWLEN   = LAST_BEAT;
    assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WDATA   = {(DW / 32){FILL_PATTERN}};
    assign M_AXI_WSTRB   = '1;

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            aw_sent       <= '0;
            w_bursts_done <= '0;
            b_rcvd        <= '0;
            aw_addr       <= BASE_ADDR;
            outstanding   <= '0;
            beat          <= '0;
            error_count   <= '0;
        end else if (state == IDLE) begin
            if (erase_ram) begin
                state         <= RUN;
                aw_sent       <= '0;
                w_bursts_done <= '0;
                b_rcvd        <= '0;
                aw_addr       <= BASE_ADDR;
                outstanding   <= '0;
                beat          <= '0;
                error_count   <= '0;
            end
        end else begin
            if (b_rcvd == TOTAL) begin
                state <= IDLE;
            end
            if (aw_hs) begin
                aw_sent <= aw_sent + 64'd1;
                aw_addr <= aw_addr + BURST_BYTES;
            end
            if (w_hs) begin
                if (M_AXI_WLAST) begin
                    beat          <= '0;
                    w_bursts_done <= w_bursts_done + 64'd1;
                end else begin
                    beat <= beat + 8'd1;
                end
            end
            if (b_hs) begin
                b_rcvd <= b_rcvd + 64'd1;
                if ((M_AXI_BRESP != 2'b00) && (error_count != 16'hFFFF)) begin
                    error_count <= error_count + 16'd1;
                end
            end
            case ({aw_hs, b_hs})
                2'b10:   outstanding <= outstanding + 8'd1;
                2'b01:   outstanding <= outstanding - 8'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_bank_eraser.sv
// Bench for bank_eraser: 16-burst bank, 2 outstanding, AXI slave stub with
// configurable ready/response behaviour and a counting model checked every cycle.
module tb_bank_eraser;
    localparam int          DW      = 512;
    localparam logic [63:0] BASE    = 64'h0000_0004_0001_0000;
    localparam logic [63:0] BSIZE   = 64'd16384;
    localparam int          BEATS   = 16;
    localparam int          MAXO    = 2;
    localparam logic [31:0] PAT     = 32'hA5C3_0F96;
    localparam int          TOTAL   = 16;
    localparam int          BURST_B = 1024;
    localparam logic [DW-1:0] EXP_DATA = {(DW / 32){PAT}};

    logic            clk = 1'b0;
    logic            resetn;
    logic            erase_ram;
    logic            erase_idle;
    logic [15:0]     error_count;
    logic [63:0]     M_AXI_AWADDR;
    logic [7:0]      M_AXI_AWLEN;
    logic [2:0]      M_AXI_AWSIZE;
    logic [1:0]      M_AXI_AWBURST;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WLAST;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP;
    logic            M_AXI_BVALID;
    logic            M_AXI_BREADY;

    bank_eraser #(
        .DW(DW), .BASE_ADDR(BASE), .BANK_SIZE(BSIZE), .BURST_BEATS(BEATS),
        .MAX_OUTSTANDING(MAXO), .FILL_PATTERN(PAT)
    ) dut (
        .clk(clk), .resetn(resetn), .erase_ram(erase_ram), .erase_idle(erase_idle),
        .error_count(error_count), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus knobs
    bit chk_en = 0;
    bit wr_rand = 0;
    bit b_rand = 0;
    bit b_hold = 0;
    bit err_en = 0;
    bit stray = 0;

    // Transaction-count model: what the master must be doing given what has been accepted so far
    bit          m_busy = 0;
    int          m_aw = 0;
    int          m_wb = 0;
    int          m_beat = 0;
    int          m_b = 0;
    logic [15:0] m_err = '0;
    bit          b_hs_last = 0;

    // Per-erase statistics taken from the DUT pins, pinned by literal checks
    int          s_aw = 0;
    int          s_beats = 0;
    int          s_wlast = 0;
    int          s_busy = 0;
    logic [63:0] s_last_addr = '0;

    always @(negedge clk) begin : monitor
        logic e_aw;
        logic e_w;
        e_aw = m_busy && (m_aw < TOTAL) && ((m_aw - m_b) < MAXO);
        e_w  = m_busy && (m_wb < m_aw);
        if (chk_en) begin
            chk("erase_idle", erase_idle, !m_busy);
            chk("awvalid", M_AXI_AWVALID, e_aw);
            chk("wvalid", M_AXI_WVALID, e_w);
            chk("bready", M_AXI_BREADY, m_busy);
            chk("error_count", error_count, m_err);
            if (e_aw) begin
                chk("awaddr", M_AXI_AWADDR, BASE + 64'(m_aw * BURST_B));
                chk("awlen", M_AXI_AWLEN, 8'd15);
                chk("awsize", M_AXI_AWSIZE, 3'd6);
                chk("awburst", M_AXI_AWBURST, 2'b01);
            end
            if (e_w) begin
                chk("wlast", M_AXI_WLAST, m_beat == BEATS - 1);
                chk("wdata", M_AXI_WDATA, EXP_DATA);
                chk("wstrb", M_AXI_WSTRB, {(DW/8){1'b1}});
            end
            if (!erase_idle) s_busy++;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                s_aw++;
                s_last_addr = M_AXI_AWADDR;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                s_beats++;
                if (M_AXI_WLAST) s_wlast++;
            end
        end
        b_hs_last = 0;
        if (!resetn) begin
            m_busy = 0; m_aw = 0; m_wb = 0; m_beat = 0; m_b = 0; m_err = '0;
        end else if (!m_busy) begin
            if (erase_ram) begin
                m_busy = 1; m_aw = 0; m_wb = 0; m_beat = 0; m_b = 0; m_err = '0;
                s_aw = 0; s_beats = 0; s_wlast = 0; s_busy = 0;
            end
        end else begin
            if (m_b == TOTAL) m_busy = 0;
            if (e_aw && M_AXI_AWREADY) m_aw++;
            if (e_w && M_AXI_WREADY) begin
                if (m_beat == BEATS - 1) begin
                    m_beat = 0;
                    m_wb++;
                end else begin
                    m_beat++;
                end
            end
            if (M_AXI_BVALID) begin
                m_b++;
                b_hs_last = 1;
                if (M_AXI_BRESP != 2'b00 && m_err != 16'hFFFF) m_err++;
            end
        end
    end

    // AXI slave stub: responds to each completed burst in order, with optional delay/hold/errors
    initial begin : slave
        int b_wait;
        b_wait = 0;
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            M_AXI_WREADY = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stray) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP  = 2'b10;
            end else if (!m_busy) begin
                M_AXI_BVALID = 1'b0;
                M_AXI_BRESP  = 2'b00;
                b_wait = 0;
            end else if (!(M_AXI_BVALID && !b_hs_last)) begin
                M_AXI_BVALID = 1'b0;
                if (b_wait > 0) begin
                    b_wait--;
                end else if (!b_hold && m_wb > m_b) begin
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP  = (err_en && (m_b == 2 || m_b == 6)) ? 2'b10 : 2'b00;
                    b_wait = b_rand ? int'($urandom_range(0, 6)) : 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_erase(input string tag);
        erase_ram = 1'b1;
        tick();
        erase_ram = 1'b0;
        chk({tag, "_idle_fall"}, erase_idle, 1'b0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && erase_idle !== 1'b1; i++) tick();
        chk({tag, "_done"}, erase_idle, 1'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_idle"}, erase_idle, 1'b1);
        chk({tag, "_awvalid"}, M_AXI_AWVALID, 1'b0);
        chk({tag, "_wvalid"}, M_AXI_WVALID, 1'b0);
        chk({tag, "_bready"}, M_AXI_BREADY, 1'b0);
        chk({tag, "_err"}, error_count, 16'd0);
    endtask

    initial begin
        resetn = 1'b0;
        erase_ram = 1'b0;
        tick();
        tick();
        chk_en = 1;
        chk_reset_state("rst");
        resetn = 1'b1;
        tick();
        tick();

        // Zero backpressure
        start_erase("t1");
        wait_idle("t1", 3000);
        chk("t1_aw_count", s_aw, 16);
        chk("t1_beats", s_beats, 256);
        chk("t1_wlast", s_wlast, 16);
        chk("t1_last_addr", s_last_addr, 64'h0000_0004_0001_3C00);
        chk("t1_busy_min", s_busy >= 256, 1'b1);
        chk("t1_err", error_count, 16'd0);

        // Write responses held off: outstanding limit stops AW issue
        b_hold = 1;
        start_erase("t2");
        repeat (100) tick();
        chk("t2_aw_held", s_aw, 2);
        chk("t2_awvalid_low", M_AXI_AWVALID, 1'b0);
        chk("t2_beats_held", s_beats, 32);
        b_hold = 0;
        wait_idle("t2", 3000);
        chk("t2_aw_count", s_aw, 16);

        // Random W backpressure and B latency
        wr_rand = 1;
        b_rand = 1;
        start_erase("t3");
        wait_idle("t3", 5000);
        chk("t3_aw_count", s_aw, 16);
        chk("t3_beats", s_beats, 256);
        chk("t3_wlast", s_wlast, 16);
        wr_rand = 0;
        b_rand = 0;

        // SLVERR on bursts 3 and 7, stray BVALID while idle, then clear on restart
        err_en = 1;
        start_erase("t4");
        wait_idle("t4", 3000);
        chk("t4_err_count", error_count, 16'd2);
        err_en = 0;
        stray = 1;
        repeat (5) tick();
        stray = 0;
        tick();
        chk("t4_stray_ignored", error_count, 16'd2);
        start_erase("t4b");
        tick();
        chk("t4b_err_cleared", error_count, 16'd0);
        wait_idle("t4b", 3000);
        chk("t4b_err", error_count, 16'd0);

        // Restart strobe while busy is ignored
        start_erase("t5");
        repeat (20) tick();
        erase_ram = 1'b1;
        tick();
        erase_ram = 1'b0;
        wait_idle("t5", 3000);
        chk("t5_aw_count", s_aw, 16);
        chk("t5_beats", s_beats, 256);

        // Reset mid-burst aborts, then a fresh erase completes normally
        tick();
        start_erase("t6");
        repeat (30) tick();
        resetn = 1'b0;
        tick();
        chk_reset_state("t6_rst");
        resetn = 1'b1;
        tick();
        start_erase("t6b");
        wait_idle("t6b", 3000);
        chk("t6b_aw_count", s_aw, 16);
        chk("t6b_beats", s_beats, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
